// File: rtl/traffic_phase_controller_if.sv
// Sensor-to-lamp bundle for traffic_phase_controller.
// master = sensor/stimulus side, slave = the phase controller.
interface traffic_phase_controller_if;
  logic pedestrian_button;
  logic turn_sensor;
  logic pedestrian_green;
  logic up_green;
  logic down_green;
  logic turn_green;

  modport master (
    output pedestrian_button, turn_sensor,
    input  pedestrian_green, up_green, down_green, turn_green
  );

  modport slave (
    input  pedestrian_button, turn_sensor,
    output pedestrian_green, up_green, down_green, turn_green
  );
endinterface

// File: rtl/traffic_phase_controller.sv
// Intersection phase sequencer: MAIN / TURN / PED with all-red CLEAR between phases.
// Optional TURN_EXTEND_EN: TURN held while turn_sensor stays high, capped at TURN_MAX.
module traffic_phase_controller #(
  parameter int unsigned MIN_GREEN  = 8,
  parameter int unsigned TURN_TIME  = 4,
  parameter int unsigned PED_TIME   = 6,
  parameter int unsigned CLEAR_TIME = 2,
  parameter int unsigned TURN_MAX   = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  traffic_phase_controller_if.slave   bus
);

  localparam int unsigned MAX_AB = (MIN_GREEN > TURN_TIME) ? MIN_GREEN : TURN_TIME;
  localparam int unsigned MAX_CD = (PED_TIME > CLEAR_TIME) ? PED_TIME : CLEAR_TIME;
  localparam int unsigned MAX_AD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned MAX_P  = (MAX_AD > TURN_MAX) ? MAX_AD : TURN_MAX;
  localparam int unsigned TW     = $clog2(MAX_P) + 1;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_MAIN  = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;
  localparam logic [1:0] S_PED   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    next_q, next_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ped_req_q, ped_req_d;
  logic          turn_req_q, turn_req_d;
  logic          last_turn_q, last_turn_d;
  logic [1:0]    sel_phase;
  logic          turn_done;
  logic          enter_ped, enter_turn;

  // With both pending, alternate away from whichever phase was served last.
  always_comb begin
    sel_phase = S_TURN;
    if (ped_req_q && turn_req_q) sel_phase = last_turn_q ? S_PED : S_TURN;
    else if (ped_req_q)          sel_phase = S_PED;
  end

`ifdef TURN_EXTEND_EN
  assign turn_done = (timer_q >= TW'(TURN_TIME - 1)) &&
                     (!bus.turn_sensor || (timer_q >= TW'(TURN_MAX - 1)));
`else
  assign turn_done = (timer_q >= TW'(TURN_TIME - 1));
`endif

  always_comb begin
    state_d = state_q;
    next_d  = next_q;
    case (state_q)
      S_CLEAR: if (timer_q >= TW'(CLEAR_TIME - 1)) state_d = next_q;
      S_MAIN: begin
        if ((timer_q >= TW'(MIN_GREEN - 1)) && (ped_req_q || turn_req_q)) begin
          state_d = S_CLEAR;
          next_d  = sel_phase;
        end
      end
      S_TURN: begin
        if (turn_done) begin
          state_d = S_CLEAR;
          next_d  = S_MAIN;
        end
      end
      S_PED: begin
        if (timer_q >= TW'(PED_TIME - 1)) begin
          state_d = S_CLEAR;
          next_d  = S_MAIN;
        end
      end
      default: begin
        state_d = S_CLEAR;
        next_d  = S_MAIN;
      end
    endcase
  end

  assign enter_ped  = (state_d == S_PED)  && (state_q != S_PED);
  assign enter_turn = (state_d == S_TURN) && (state_q != S_TURN);

  // Timer counts cycles spent in the current state; it saturates in MAIN once min-green is met.
  always_comb begin
    timer_d = timer_q + TW'(1);
    if (state_d != state_q)
      timer_d = '0;
    else if ((state_q == S_MAIN) && (timer_q >= TW'(MIN_GREEN - 1)))
      timer_d = timer_q;
  end

  always_comb begin
    ped_req_d   = ped_req_q;
    turn_req_d  = turn_req_q;
    last_turn_d = last_turn_q;
    if (bus.pedestrian_button && (state_q != S_PED)) ped_req_d  = 1'b1;
    if (bus.turn_sensor && (state_q != S_TURN))      turn_req_d = 1'b1;
    if (enter_ped) begin
      ped_req_d   = 1'b0;
      last_turn_d = 1'b0;
    end
    if (enter_turn) begin
      turn_req_d  = 1'b0;
      last_turn_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_CLEAR;
      next_q      <= S_MAIN;
      timer_q     <= '0;
      ped_req_q   <= 1'b0;
      turn_req_q  <= 1'b0;
      last_turn_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      next_q      <= next_d;
      timer_q     <= timer_d;
      ped_req_q   <= ped_req_d;
      turn_req_q  <= turn_req_d;
      last_turn_q <= last_turn_d;
    end
  end

  assign bus.pedestrian_green = (state_q == S_PED);
  assign bus.up_green         = (state_q == S_MAIN) || (state_q == S_TURN);
  assign bus.down_green       = (state_q == S_MAIN);
  assign bus.turn_green       = (state_q == S_TURN);

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed scoreboard bench for traffic_phase_controller (default parameters).
// Expected lamp vectors {ped, up, down, turn} are queued per cycle and popped after each edge.
module tb_traffic_phase_controller;

  localparam logic [3:0] CLR  = 4'b0000;
  localparam logic [3:0] MAIN = 4'b0110;
  localparam logic [3:0] TURN = 4'b0101;
  localparam logic [3:0] PED  = 4'b1000;
`ifdef TURN_EXTEND_EN
  localparam int TL = 8;
`else
  localparam int TL = 4;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] greens;
  logic [3:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  string tag = "init";

  traffic_phase_controller_if bus ();

  traffic_phase_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign greens = {bus.pedestrian_green, bus.up_green, bus.down_green, bus.turn_green};

  always #5 clock = ~clock;

  task automatic push(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic check(input logic [3:0] exp_v);
    logic [3:0] obs;
    obs = greens;
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s greens observed=%b expected=%b", tag, obs, exp_v);
    end
    checks++;
    assert (((obs[3] & obs[2]) | (obs[3] & obs[1]) | (obs[0] & obs[1])) === 1'b0) else begin
      errors++;
      $error("FAIL %s_exclusion greens observed=%b expected=no_conflict", tag, obs);
    end
  endtask

  task automatic step(input logic p, input logic t);
    bus.pedestrian_button = p;
    bus.turn_sensor       = t;
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
    end else begin
      check(exp_q.pop_front());
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) step(1'b0, 1'b0);
  endtask

  // Leaves the DUT in MAIN cycle 1, sampled just after the entering edge.
  task automatic do_reset();
    bus.pedestrian_button = 1'b0;
    bus.turn_sensor       = 1'b0;
    reset = 1'b0;
    #1;
    check(CLR);
    push(CLR, 2);
    drain();
    reset = 1'b1;
    check(CLR);
    push(CLR, 1);
    push(MAIN, 1);
    drain();
  endtask

  initial begin
    bus.pedestrian_button = 1'b0;
    bus.turn_sensor       = 1'b0;
    #2;

    tag = "power_up";
    do_reset();
    push(MAIN, 49);
    drain();

    tag = "ped_pulse";
    do_reset();
    push(MAIN, 2);
    drain();
    push(MAIN, 1);
    step(1'b1, 1'b0);
    push(MAIN, 4); push(CLR, 2); push(PED, 6); push(CLR, 2); push(MAIN, 10);
    drain();

    tag = "turn_pulse";
    push(MAIN, 1);
    step(1'b0, 1'b1);
    push(CLR, 2); push(TURN, 4); push(CLR, 2); push(MAIN, 10);
    drain();

    tag = "both_pend";
    do_reset();
    push(MAIN, 1);
    step(1'b1, 1'b1);
    push(MAIN, 6); push(CLR, 2); push(PED, 6); push(CLR, 2); push(MAIN, 8);
    push(CLR, 2); push(TURN, 4); push(CLR, 2); push(MAIN, 2);
    drain();

    tag = "alternate";
    push(MAIN, 1);
    step(1'b1, 1'b0);
    push(MAIN, 5); push(CLR, 2);
    drain();
    push(PED, 1);
    step(1'b0, 1'b1);
    push(PED, 5);
    drain();
    push(CLR, 1);
    step(1'b0, 1'b0);
    push(CLR, 1);
    step(1'b1, 1'b0);
    push(MAIN, 8); push(CLR, 2); push(TURN, 4); push(CLR, 2); push(MAIN, 8);
    push(CLR, 2); push(PED, 6); push(CLR, 2); push(MAIN, 3);
    drain();

    tag = "rst_mid_ped";
    do_reset();
    push(MAIN, 1);
    step(1'b1, 1'b0);
    push(MAIN, 6); push(CLR, 2);
    drain();
    push(PED, 1);
    step(1'b0, 1'b1);
    push(PED, 2);
    drain();
    reset = 1'b0;
    #1;
    check(CLR);
    push(CLR, 2);
    drain();
    reset = 1'b1;
    check(CLR);
    push(CLR, 1); push(MAIN, 20);
    drain();

    tag = "turn_hold";
    do_reset();
    push(MAIN, 7); push(CLR, 2); push(TURN, TL); push(CLR, 2); push(MAIN, 8);
    push(CLR, 2); push(TURN, 4); push(CLR, 2); push(MAIN, 4);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
